// File: rtl/rsa_pkg.sv
// Key constants and FSM encodings for the RSA encrypt/decrypt path.
package rsa_pkg;

    localparam int unsigned N  = 10573;
    localparam int unsigned E  = 89;
    localparam int unsigned W  = 14;
    localparam int unsigned EW = 7;
    localparam int unsigned KW = $clog2(EW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SQR  = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    function automatic int unsigned popcount(input int unsigned v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) cnt++;
        end
        return cnt;
    endfunction

    // Accept edge to ct_valid rising, in cycles.
    localparam int unsigned LATENCY = 1 + (EW + popcount(E)) * (W + 2);

endpackage

// File: rtl/mod_mult.sv
// Bit-serial interleaved modular multiplier: p = a*b mod N, multiplier bits MSB first.
module mod_mult #(
    parameter int unsigned N = 10573,
    parameter int unsigned W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned AW = W + 1;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [AW-1:0] N_A = AW'(N);

    logic [AW-1:0] acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] dbl_c, dbl_red_c, sum_c, sum_red_c;

    // One iteration: double-and-reduce, then conditionally add-and-reduce.
    always_comb begin
        dbl_c     = acc_q << 1;
        dbl_red_c = (dbl_c >= N_A) ? dbl_c - N_A : dbl_c;
        sum_c     = dbl_red_c + AW'(a_q);
        sum_red_c = (sum_c >= N_A) ? sum_c - N_A : sum_c;

        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            acc_d  = '0;
            a_d    = a;
            b_d    = b;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = b_q[W-1] ? sum_red_c : dbl_red_c;
            b_d   = b_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                p_d    = acc_d[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/rsa_encryptor.sv
// RSA encrypt: ct = msg^E mod N by left-to-right square-and-multiply over mod_mult.
module rsa_encryptor
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [W-1:0] msg_in,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [W-1:0] ct_out,
    output logic         ct_err
);

    localparam logic [EW-1:0] E_BITS = EW'(E);
    localparam logic [W-1:0]  N_W    = W'(N);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  m_q, m_d;
    logic [KW-1:0] k_q, k_d;
    logic          err_q, err_d;
    logic          wait_q, wait_d;
    logic          msg_ready_q, msg_ready_d;
    logic          ct_valid_q, ct_valid_d;
    logic [W-1:0]  ct_out_q, ct_out_d;
    logic          ct_err_q, ct_err_d;

    logic          start_c;
    logic [W-1:0]  mult_b_c;
    logic          mult_done;
    logic [W-1:0]  mult_p;

    mod_mult #(
        .N (N),
        .W (W)
    ) u_mod_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_c),
        .a     (r_q),
        .b     (mult_b_c),
        .done  (mult_done),
        .p     (mult_p)
    );

    // Exponent scan: each SQR/MUL step is issue, W iterations, then writeback.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        m_d      = m_q;
        k_d      = k_q;
        err_d    = err_q;
        wait_d   = wait_q;
        start_c  = 1'b0;
        mult_b_c = (state_q == ST_MUL) ? m_q : r_q;

        case (state_q)
            ST_IDLE: begin
                if (msg_valid && msg_ready_q) begin
                    m_d = msg_in;
                    k_d = KW'(EW - 1);
                    if (msg_in >= N_W) begin
                        r_d     = '0;
                        err_d   = 1'b1;
                        state_d = ST_OUT;
                    end else begin
                        r_d     = W'(1);
                        err_d   = 1'b0;
                        state_d = ST_SQR;
                    end
                end
            end
            ST_SQR, ST_MUL: begin
                if (!wait_q) begin
                    start_c = 1'b1;
                    wait_d  = 1'b1;
                end else if (mult_done) begin
                    wait_d = 1'b0;
                    r_d    = mult_p;
                    if (state_q == ST_SQR && E_BITS[k_q]) begin
                        state_d = ST_MUL;
                    end else if (k_q == '0) begin
                        state_d = ST_OUT;
                    end else begin
                        k_d     = k_q - KW'(1);
                        state_d = ST_SQR;
                    end
                end
            end
            ST_OUT: begin
                if (ct_valid_q && ct_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Result is captured on the first OUT cycle and held until the handshake.
        ct_valid_d = (state_q == ST_OUT) && !(ct_valid_q && ct_ready);
        ct_out_d   = ct_out_q;
        ct_err_d   = ct_err_q;
        if (state_q == ST_OUT && !ct_valid_q) begin
            ct_out_d = r_q;
            ct_err_d = err_q;
        end
        msg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            m_q         <= '0;
            k_q         <= '0;
            err_q       <= 1'b0;
            wait_q      <= 1'b0;
            msg_ready_q <= 1'b1;
            ct_valid_q  <= 1'b0;
            ct_out_q    <= '0;
            ct_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            m_q         <= m_d;
            k_q         <= k_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            msg_ready_q <= msg_ready_d;
            ct_valid_q  <= ct_valid_d;
            ct_out_q    <= ct_out_d;
            ct_err_q    <= ct_err_d;
        end
    end

    assign msg_ready = msg_ready_q;
    assign ct_valid  = ct_valid_q;
    assign ct_out    = ct_out_q;
    assign ct_err    = ct_err_q;

endmodule
